// File: rtl/ex.sv
// Execute stage: single-cycle logic/shift/arith ALU plus an iterative radix-2
// restoring divider that stalls the front of the pipeline while it runs.
module ex (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [2:0]  alusel_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic        flush_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stallreq_o
);
    localparam logic [2:0] EXE_RES_NONE  = 3'd0;
    localparam logic [2:0] EXE_RES_LOGIC = 3'd1;
    localparam logic [2:0] EXE_RES_SHIFT = 3'd2;
    localparam logic [2:0] EXE_RES_ARITH = 3'd3;
    localparam logic [2:0] EXE_RES_DIV   = 3'd4;

    localparam logic [7:0] EXE_AND  = 8'h24;
    localparam logic [7:0] EXE_OR   = 8'h25;
    localparam logic [7:0] EXE_XOR  = 8'h26;
    localparam logic [7:0] EXE_SLL  = 8'h7c;
    localparam logic [7:0] EXE_SRL  = 8'h02;
    localparam logic [7:0] EXE_SRA  = 8'h03;
    localparam logic [7:0] EXE_ADD  = 8'h20;
    localparam logic [7:0] EXE_SUB  = 8'h22;
    localparam logic [7:0] EXE_SLT  = 8'h2a;
    localparam logic [7:0] EXE_SLTU = 8'h2b;
    localparam logic [7:0] EXE_DIV  = 8'h1a;
    localparam logic [7:0] EXE_DIVU = 8'h1b;
    localparam logic [7:0] EXE_REM  = 8'h1c;
    localparam logic [7:0] EXE_REMU = 8'h1d;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state_reg, state_next;
    logic [4:0]  cnt_reg;
    logic [31:0] rem_reg, quot_reg, divisor_reg;
    logic        qsign_reg, rsign_reg, is_rem_reg;

    logic        is_div, is_signed, sign1, sign2, overflow;
    logic [31:0] abs1, abs2, alu_res, div_res;
    logic [32:0] shifted, diff;
    logic        div_stall, div_done;

    assign is_div    = (alusel_i == EXE_RES_DIV) &&
                       (aluop_i == EXE_DIV || aluop_i == EXE_DIVU ||
                        aluop_i == EXE_REM || aluop_i == EXE_REMU);
    assign is_signed = (aluop_i == EXE_DIV) || (aluop_i == EXE_REM);
    assign sign1     = is_signed & reg1_i[31];
    assign sign2     = is_signed & reg2_i[31];
    assign abs1      = sign1 ? -reg1_i : reg1_i;
    assign abs2      = sign2 ? -reg2_i : reg2_i;
    assign overflow  = is_signed && (reg1_i == 32'h8000_0000) && (reg2_i == 32'hffff_ffff);

    // Trial subtraction: bring down the next dividend bit into the partial remainder.
    assign shifted = {rem_reg, quot_reg[31]};
    assign diff    = shifted - {1'b0, divisor_reg};

    always_comb begin
        alu_res = 32'd0;
        case (alusel_i)
            EXE_RES_LOGIC: begin
                case (aluop_i)
                    EXE_OR:  alu_res = reg1_i | reg2_i;
                    EXE_AND: alu_res = reg1_i & reg2_i;
                    EXE_XOR: alu_res = reg1_i ^ reg2_i;
                    default: alu_res = 32'd0;
                endcase
            end
            EXE_RES_SHIFT: begin
                case (aluop_i)
                    EXE_SLL: alu_res = reg1_i << reg2_i[4:0];
                    EXE_SRL: alu_res = reg1_i >> reg2_i[4:0];
                    EXE_SRA: alu_res = $unsigned($signed(reg1_i) >>> reg2_i[4:0]);
                    default: alu_res = 32'd0;
                endcase
            end
            EXE_RES_ARITH: begin
                case (aluop_i)
                    EXE_ADD:  alu_res = reg1_i + reg2_i;
                    EXE_SUB:  alu_res = reg1_i - reg2_i;
                    EXE_SLT:  alu_res = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
                    EXE_SLTU: alu_res = {31'd0, reg1_i < reg2_i};
                    default:  alu_res = 32'd0;
                endcase
            end
            default: alu_res = 32'd0;
        endcase
    end

    always_comb begin
        if (is_rem_reg)
            div_res = rsign_reg ? -rem_reg : rem_reg;
        else
            div_res = qsign_reg ? -quot_reg : quot_reg;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        div_stall  = 1'b0;
        div_done   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (is_div) begin
                    div_stall  = 1'b1;
                    state_next = (reg2_i == 32'd0 || overflow) ? DONE : CALC;
                end
            end
            CALC: begin
                div_stall = 1'b1;
                if (cnt_reg == 5'd31)
                    state_next = DONE;
            end
            DONE: begin
                div_done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (flush_i) begin
            state_next = IDLE;
            div_stall  = 1'b0;
            div_done   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg     <= 5'd0;
            rem_reg     <= 32'd0;
            quot_reg    <= 32'd0;
            divisor_reg <= 32'd0;
            qsign_reg   <= 1'b0;
            rsign_reg   <= 1'b0;
            is_rem_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (is_div && !flush_i) begin
                        cnt_reg    <= 5'd0;
                        is_rem_reg <= (aluop_i == EXE_REM) || (aluop_i == EXE_REMU);
                        if (reg2_i == 32'd0) begin
                            quot_reg  <= 32'hffff_ffff;
                            rem_reg   <= reg1_i;
                            qsign_reg <= 1'b0;
                            rsign_reg <= 1'b0;
                        end else if (overflow) begin
                            quot_reg  <= 32'h8000_0000;
                            rem_reg   <= 32'd0;
                            qsign_reg <= 1'b0;
                            rsign_reg <= 1'b0;
                        end else begin
                            quot_reg    <= abs1;
                            rem_reg     <= 32'd0;
                            divisor_reg <= abs2;
                            qsign_reg   <= sign1 ^ sign2;
                            rsign_reg   <= sign1;
                        end
                    end
                end
                CALC: begin
                    cnt_reg  <= cnt_reg + 5'd1;
                    quot_reg <= {quot_reg[30:0], ~diff[32]};
                    rem_reg  <= diff[32] ? shifted[31:0] : diff[31:0];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        wd_o       = wd_i;
        wreg_o     = wreg_i;
        wdata_o    = div_done ? div_res : alu_res;
        stallreq_o = div_stall;
        if (div_stall || flush_i)
            wreg_o = 1'b0;
        if (rst) begin
            wd_o       = 5'd0;
            wreg_o     = 1'b0;
            wdata_o    = 32'd0;
            stallreq_o = 1'b0;
        end
    end
endmodule
